// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream merge: packet-locked grants feeding a 2-entry output skid FIFO.
// state | meaning: ST_IDLE = arbitrating among masked valids; ST_LOCKED = slot `grant` owns the output until its tlast is pushed
module axis_rr_arbiter #(
  parameter int C_NUM_SI_SLOTS     = 3,
  parameter int C_AXIS_TDATA_WIDTH = 72,
  parameter int C_TID_WIDTH        = 2
) (
  input  logic                                         aclk,
  input  logic                                         areset,
  input  logic [C_NUM_SI_SLOTS-1:0]                    arb_mask,
  input  logic [C_NUM_SI_SLOTS-1:0]                    s_axis_tvalid,
  output logic [C_NUM_SI_SLOTS-1:0]                    s_axis_tready,
  input  logic [C_NUM_SI_SLOTS*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_SI_SLOTS-1:0]                    s_axis_tlast,
  output logic                                         m_axis_tvalid,
  input  logic                                         m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                m_axis_tdata,
  output logic                                         m_axis_tlast,
  output logic [C_TID_WIDTH-1:0]                       m_axis_tid
);
  localparam int N  = C_NUM_SI_SLOTS;
  localparam int W  = C_AXIS_TDATA_WIDTH;
  localparam int TW = C_TID_WIDTH;
  localparam int EW = W + 1 + TW;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t        state;
  logic [TW-1:0] grant;
  logic [TW-1:0] last_grant;
  logic [TW-1:0] winner;
  logic          found;
  logic [N-1:0]  cand;
  logic [N-1:0]  slot_sel;
  logic [W-1:0]  sel_data;
  logic          sel_valid;
  logic          sel_last;
  logic          can_push;
  logic          push;
  logic          pop;
  logic [1:0]    count;
  logic [EW-1:0] ent0;
  logic [EW-1:0] ent1;
  logic [EW-1:0] din;

  assign cand = s_axis_tvalid & arb_mask;

  // Two passes give the rotating priority: slots above last_grant first, then wrap to the rest.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && cand[i] && (i > int'(last_grant))) begin
        found  = 1'b1;
        winner = TW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && cand[i] && (i <= int'(last_grant))) begin
        found  = 1'b1;
        winner = TW'(i);
      end
    end
  end

  always_comb begin
    slot_sel  = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant == TW'(i)) begin
        slot_sel[i] = 1'b1;
        sel_data    = s_axis_tdata[i*W +: W];
        sel_valid   = s_axis_tvalid[i];
        sel_last    = s_axis_tlast[i];
      end
    end
  end

  assign can_push      = (state == ST_LOCKED) && (count != 2'd2) && !areset;
  assign s_axis_tready = {N{can_push}} & slot_sel;
  assign push          = can_push & sel_valid;
  assign m_axis_tvalid = (count != 2'd0) && !areset;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign din           = {grant, sel_last, sel_data};

  assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = ent0;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= TW'(N - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state      <= ST_LOCKED;
            grant      <= winner;
            last_grant <= winner;
          end
        end
        ST_LOCKED: begin
          if (push && sel_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ent0 is always the head, so the output pins come straight from flops.
  always_ff @(posedge aclk) begin
    if (areset) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: ent0 <= din;
        default: ;
      endcase
    end
  end

endmodule
